// File: rtl/rs_pkg.sv
// Shared reservation-station types and default widths.
// The rename stage uses the same constants to build allocation bundles.
package rs_pkg;

    localparam int DEF_WIDTH   = 31;
    localparam int DEF_ROB     = 2;
    localparam int DEF_CTRL    = 3;
    localparam int DEF_ENTRIES = 4;

    typedef struct packed {
        logic                 valid;
        logic [DEF_CTRL:0]    ctrl;
        logic [DEF_ROB:0]     rob;
        logic [DEF_WIDTH:0]   value1;
        logic [DEF_WIDTH:0]   value2;
        logic                 ready1;
        logic                 ready2;
        logic [DEF_ROB:0]     tag1;
        logic [DEF_ROB:0]     tag2;
    } rs_entry_t;

endpackage

// File: rtl/rs_select.sv
// Find-first over the per-entry issue requests.
// The lowest index wins, which is the oldest entry.
module rs_select #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    output logic [$clog2(N)-1:0] idx,
    output logic                 found
);

    localparam int IW = $clog2(N);

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IW'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rs_issue_scheduler.sv
// Age-ordered collapsing reservation station with CDB wakeup
// and a single registered issue port toward one functional unit.
module rs_issue_scheduler
    import rs_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int ROB     = DEF_ROB,
    parameter int CTRL    = DEF_CTRL,
    parameter int ENTRIES = DEF_ENTRIES
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           alloc_valid,
    output logic                           alloc_ready,
    input  logic [CTRL:0]                  alloc_ctrl,
    input  logic [ROB:0]                   alloc_rob,
    input  logic [WIDTH:0]                 alloc_value1,
    input  logic [WIDTH:0]                 alloc_value2,
    input  logic                           alloc_ready1,
    input  logic                           alloc_ready2,
    input  logic [ROB:0]                   alloc_tag1,
    input  logic [ROB:0]                   alloc_tag2,
    input  logic                           cdb_valid,
    input  logic [ROB:0]                   cdb_rob,
    input  logic [WIDTH:0]                 cdb_value,
    output logic                           issue_valid,
    input  logic                           issue_ready,
    output logic [CTRL:0]                  issue_ctrl,
    output logic [ROB:0]                   issue_rob,
    output logic [WIDTH:0]                 issue_value1,
    output logic [WIDTH:0]                 issue_value2,
    output logic [$clog2(ENTRIES+1)-1:0]   count
);

    localparam int IW = $clog2(ENTRIES);
    localparam int CW = $clog2(ENTRIES + 1);

    rs_entry_t ent [ENTRIES];
    rs_entry_t nxt [ENTRIES];
    rs_entry_t new_e;

    logic [ENTRIES-1:0] req;
    logic [IW-1:0]      sel;
    logic               found;
    logic               load;
    logic               take;
    logic               acc;
    logic               hit1;
    logic               hit2;
    logic [CW-1:0]      base;

    always_comb begin
        req = '0;
        for (int i = 0; i < ENTRIES; i++)
            req[i] = ent[i].valid & ent[i].ready1 & ent[i].ready2;
    end

    rs_select #(.N(ENTRIES)) u_sel (
        .req   (req),
        .idx   (sel),
        .found (found)
    );

    // Departures are deliberately not credited to alloc_ready.
    assign alloc_ready = count < CW'(ENTRIES);
    assign load        = !issue_valid || issue_ready;
    assign take        = load && found;
    assign acc         = alloc_valid && alloc_ready;
    assign base        = count - CW'(take);
    assign hit1        = cdb_valid && !alloc_ready1 && (alloc_tag1 == cdb_rob);
    assign hit2        = cdb_valid && !alloc_ready2 && (alloc_tag2 == cdb_rob);

    always_comb begin
        new_e        = '0;
        new_e.valid  = 1'b1;
        new_e.ctrl   = alloc_ctrl;
        new_e.rob    = alloc_rob;
        new_e.tag1   = alloc_tag1;
        new_e.tag2   = alloc_tag2;
        new_e.ready1 = alloc_ready1 | hit1;
        new_e.ready2 = alloc_ready2 | hit2;
        new_e.value1 = hit1 ? cdb_value : alloc_value1;
        new_e.value2 = hit2 ? cdb_value : alloc_value2;
    end

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            nxt[i] = ent[i];
            if (cdb_valid && ent[i].valid) begin
                if (!ent[i].ready1 && ent[i].tag1 == cdb_rob) begin
                    nxt[i].ready1 = 1'b1;
                    nxt[i].value1 = cdb_value;
                end
                if (!ent[i].ready2 && ent[i].tag2 == cdb_rob) begin
                    nxt[i].ready2 = 1'b1;
                    nxt[i].value2 = cdb_value;
                end
            end
        end
        // Ascending order keeps nxt[i+1] unshifted when it is read.
        if (take) begin
            for (int i = 0; i < ENTRIES - 1; i++)
                if (i >= int'(sel))
                    nxt[i] = nxt[i+1];
            nxt[ENTRIES-1] = '0;
        end
        if (acc)
            nxt[base[IW-1:0]] = new_e;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count        <= '0;
            issue_valid  <= 1'b0;
            issue_ctrl   <= '0;
            issue_rob    <= '0;
            issue_value1 <= '0;
            issue_value2 <= '0;
            for (int i = 0; i < ENTRIES; i++)
                ent[i] <= '0;
        end else if (flush) begin
            count       <= '0;
            issue_valid <= 1'b0;
            for (int i = 0; i < ENTRIES; i++)
                ent[i] <= '0;
        end else begin
            count <= base + CW'(acc);
            for (int i = 0; i < ENTRIES; i++)
                ent[i] <= nxt[i];
            if (load) begin
                issue_valid <= found;
                if (found) begin
                    issue_ctrl   <= ent[sel].ctrl;
                    issue_rob    <= ent[sel].rob;
                    issue_value1 <= ent[sel].value1;
                    issue_value2 <= ent[sel].value2;
                end
            end
        end
    end

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Scoreboard bench for rs_issue_scheduler: expected issue payloads are
// queued as stimulus is driven and compared whenever a transfer happens.
module tb_rs_issue_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        alloc_valid;
    logic        alloc_ready;
    logic [3:0]  alloc_ctrl;
    logic [2:0]  alloc_rob;
    logic [31:0] alloc_value1;
    logic [31:0] alloc_value2;
    logic        alloc_ready1;
    logic        alloc_ready2;
    logic [2:0]  alloc_tag1;
    logic [2:0]  alloc_tag2;
    logic        cdb_valid;
    logic [2:0]  cdb_rob;
    logic [31:0] cdb_value;
    logic        issue_valid;
    logic        issue_ready;
    logic [3:0]  issue_ctrl;
    logic [2:0]  issue_rob;
    logic [31:0] issue_value1;
    logic [31:0] issue_value2;
    logic [2:0]  count;

    logic [70:0] exp_q[$];
    int vectors = 0;
    int miscompares = 0;

    rs_issue_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .alloc_valid  (alloc_valid),
        .alloc_ready  (alloc_ready),
        .alloc_ctrl   (alloc_ctrl),
        .alloc_rob    (alloc_rob),
        .alloc_value1 (alloc_value1),
        .alloc_value2 (alloc_value2),
        .alloc_ready1 (alloc_ready1),
        .alloc_ready2 (alloc_ready2),
        .alloc_tag1   (alloc_tag1),
        .alloc_tag2   (alloc_tag2),
        .cdb_valid    (cdb_valid),
        .cdb_rob      (cdb_rob),
        .cdb_value    (cdb_value),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .issue_ctrl   (issue_ctrl),
        .issue_rob    (issue_rob),
        .issue_value1 (issue_value1),
        .issue_value2 (issue_value2),
        .count        (count)
    );

    always #5 clk = ~clk;

    function automatic logic [70:0] mk(input logic [3:0] c, input logic [2:0] r,
                                       input logic [31:0] a, input logic [31:0] b);
        return {c, r, a, b};
    endfunction

    // A handshake seen at the falling edge transfers at the next rising edge.
    always @(negedge clk) begin
        logic [70:0] got;
        logic [70:0] want;
        if (!reset && !flush && issue_valid && issue_ready) begin
            vectors++;
            got = {issue_ctrl, issue_rob, issue_value1, issue_value2};
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL issue_unexpected got=%h want=none", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    miscompares++;
                    $display("FAIL issue_payload got=%h want=%h", got, want);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        flush        = 1'b0;
        alloc_valid  = 1'b0;
        alloc_ctrl   = '0;
        alloc_rob    = '0;
        alloc_value1 = '0;
        alloc_value2 = '0;
        alloc_ready1 = 1'b0;
        alloc_ready2 = 1'b0;
        alloc_tag1   = '0;
        alloc_tag2   = '0;
        cdb_valid    = 1'b0;
        cdb_rob      = '0;
        cdb_value    = '0;
    endtask

    task automatic set_alloc(input logic [3:0] c, input logic [2:0] r,
                             input logic [31:0] v1, input logic [31:0] v2,
                             input logic r1, input logic r2,
                             input logic [2:0] t1, input logic [2:0] t2);
        alloc_valid  = 1'b1;
        alloc_ctrl   = c;
        alloc_rob    = r;
        alloc_value1 = v1;
        alloc_value2 = v2;
        alloc_ready1 = r1;
        alloc_ready2 = r2;
        alloc_tag1   = t1;
        alloc_tag2   = t2;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 50 && exp_q.size() != 0; i++)
            tick();
        tick();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drain got=%0d pending want=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        issue_ready = 1'b0;
        clear_in();
        #1;
        vectors++;
        if ({issue_valid, count, alloc_ready, issue_rob, issue_value1} !== {1'b0, 3'd0, 1'b1, 3'd0, 32'd0}) begin
            miscompares++;
            $display("FAIL reset_state got=%b/%0d/%b/%0d/%h want=0/0/1/0/0",
                     issue_valid, count, alloc_ready, issue_rob, issue_value1);
        end
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_ready_instr();
        issue_ready = 1'b1;
        set_alloc(4'd1, 3'd3, 32'd5, 32'd7, 1'b1, 1'b1, 3'd0, 3'd0);
        exp_q.push_back(mk(4'd1, 3'd3, 32'd5, 32'd7));
        tick();
        clear_in();
        vectors++;
        if (count !== 3'd1 || issue_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_edge1 got=cnt%0d iv%b want=cnt1 iv0", count, issue_valid);
        end
        tick();
        vectors++;
        if (issue_valid !== 1'b1 || issue_rob !== 3'd3 || count !== 3'd0) begin
            miscompares++;
            $display("FAIL ready_edge2 got=iv%b rob%0d cnt%0d want=iv1 rob3 cnt0",
                     issue_valid, issue_rob, count);
        end
        tick();
        vectors++;
        if (issue_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_fall got=%b want=0", issue_valid);
        end
        wait_drain("ready");
    endtask

    task automatic test_wakeup();
        issue_ready = 1'b1;
        set_alloc(4'd2, 3'd1, 32'd0, 32'd9, 1'b0, 1'b1, 3'd6, 3'd0);
        exp_q.push_back(mk(4'd2, 3'd1, 32'hAB, 32'd9));
        tick();
        clear_in();
        cdb_valid = 1'b1;
        cdb_rob   = 3'd6;
        cdb_value = 32'hAB;
        tick();
        clear_in();
        vectors++;
        if (issue_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL wakeup_early got=%b want=0", issue_valid);
        end
        tick();
        vectors++;
        if (issue_valid !== 1'b1 || issue_value1 !== 32'hAB) begin
            miscompares++;
            $display("FAIL wakeup_issue got=iv%b v1=%h want=iv1 v1=ab", issue_valid, issue_value1);
        end
        wait_drain("wakeup");
    endtask

    task automatic test_age_order();
        issue_ready = 1'b1;
        set_alloc(4'd3, 3'd2, 32'd0, 32'h20, 1'b0, 1'b1, 3'd5, 3'd0);
        tick();
        set_alloc(4'd4, 3'd4, 32'h40, 32'h41, 1'b1, 1'b1, 3'd0, 3'd0);
        exp_q.push_back(mk(4'd4, 3'd4, 32'h40, 32'h41));
        exp_q.push_back(mk(4'd3, 3'd2, 32'h55, 32'h20));
        tick();
        clear_in();
        cdb_valid = 1'b1;
        cdb_rob   = 3'd5;
        cdb_value = 32'h55;
        tick();
        clear_in();
        vectors++;
        if (issue_valid !== 1'b1 || issue_rob !== 3'd4) begin
            miscompares++;
            $display("FAIL age_first got=iv%b rob%0d want=iv1 rob4", issue_valid, issue_rob);
        end
        tick();
        vectors++;
        if (issue_valid !== 1'b1 || issue_rob !== 3'd2) begin
            miscompares++;
            $display("FAIL age_second got=iv%b rob%0d want=iv1 rob2", issue_valid, issue_rob);
        end
        wait_drain("age");
    endtask

    task automatic test_full_backpressure();
        issue_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_alloc(4'(k), 3'(k), 32'(k * 3 + 1), 32'(k * 3 + 2), 1'b1, 1'b1, 3'd0, 3'd0);
            exp_q.push_back(mk(4'(k), 3'(k), 32'(k * 3 + 1), 32'(k * 3 + 2)));
            tick();
        end
        set_alloc(4'd5, 3'd5, 32'hEE, 32'hEF, 1'b1, 1'b1, 3'd0, 3'd0);
        vectors++;
        if (alloc_ready !== 1'b0 || count !== 3'd4 || issue_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL full_state got=ar%b cnt%0d iv%b want=ar0 cnt4 iv1",
                     alloc_ready, count, issue_valid);
        end
        tick();
        clear_in();
        vectors++;
        if (count !== 3'd4 || issue_rob !== 3'd0 || issue_value1 !== 32'd1) begin
            miscompares++;
            $display("FAIL full_hold got=cnt%0d rob%0d v1=%h want=cnt4 rob0 v1=1",
                     count, issue_rob, issue_value1);
        end
        issue_ready = 1'b1;
        tick();
        vectors++;
        if (alloc_ready !== 1'b1 || count !== 3'd3) begin
            miscompares++;
            $display("FAIL full_release got=ar%b cnt%0d want=ar1 cnt3", alloc_ready, count);
        end
        wait_drain("full");
    endtask

    task automatic test_same_cycle_cdb();
        issue_ready = 1'b1;
        set_alloc(4'd6, 3'd6, 32'h22, 32'hDEAD, 1'b1, 1'b0, 3'd0, 3'd2);
        cdb_valid = 1'b1;
        cdb_rob   = 3'd2;
        cdb_value = 32'h10;
        exp_q.push_back(mk(4'd6, 3'd6, 32'h22, 32'h10));
        tick();
        clear_in();
        tick();
        vectors++;
        if (issue_valid !== 1'b1 || issue_value2 !== 32'h10) begin
            miscompares++;
            $display("FAIL samecyc_issue got=iv%b v2=%h want=iv1 v2=10", issue_valid, issue_value2);
        end
        wait_drain("samecyc");
    endtask

    task automatic test_flush_and_reset();
        issue_ready = 1'b0;
        for (int k = 1; k < 5; k++) begin
            set_alloc(4'd7, 3'(k), 32'(k), 32'(k), 1'b1, 1'b1, 3'd0, 3'd0);
            tick();
        end
        clear_in();
        vectors++;
        if (count !== 3'd3 || issue_valid !== 1'b1 || issue_rob !== 3'd1) begin
            miscompares++;
            $display("FAIL flush_pre got=cnt%0d iv%b rob%0d want=cnt3 iv1 rob1",
                     count, issue_valid, issue_rob);
        end
        flush       = 1'b1;
        issue_ready = 1'b1;
        set_alloc(4'd7, 3'd7, 32'h77, 32'h77, 1'b1, 1'b1, 3'd0, 3'd0);
        tick();
        clear_in();
        issue_ready = 1'b0;
        vectors++;
        if (count !== 3'd0 || issue_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_clear got=cnt%0d iv%b want=cnt0 iv0", count, issue_valid);
        end
        tick();
        vectors++;
        if (count !== 3'd0 || issue_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_drop got=cnt%0d iv%b want=cnt0 iv0", count, issue_valid);
        end
        set_alloc(4'd1, 3'd5, 32'h5, 32'h5, 1'b1, 1'b1, 3'd0, 3'd0);
        tick();
        set_alloc(4'd1, 3'd6, 32'h6, 32'h6, 1'b1, 1'b1, 3'd0, 3'd0);
        tick();
        clear_in();
        vectors++;
        if (count !== 3'd1 || issue_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL prereset got=cnt%0d iv%b want=cnt1 iv1", count, issue_valid);
        end
        #3;
        reset = 1'b1;
        #1;
        vectors++;
        if ({issue_valid, count, alloc_ready, issue_rob, issue_value1} !== {1'b0, 3'd0, 1'b1, 3'd0, 32'd0}) begin
            miscompares++;
            $display("FAIL async_reset got=%b/%0d/%b/%0d/%h want=0/0/1/0/0",
                     issue_valid, count, alloc_ready, issue_rob, issue_value1);
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_ready_instr();
        test_wakeup();
        test_age_order();
        test_full_backpressure();
        test_same_cycle_cdb();
        test_flush_and_reset();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL leftover got=%0d want=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
